cnn_window_gen: RTL and testbench
=================================

CNN_WINDOW_GEN -- requirements
Module: cnn_window_gen

Interface
REQ-001 SHALL have parameter KX, default 3, kernel width in pixels.
REQ-002 SHALL have parameter KY, default 3, kernel height in pixels.
REQ-003 SHALL have parameter I_F_BW, default 8, pixel bit width.
REQ-004 SHALL have parameter IW, default 32, image width in pixels (IW >= KX).
REQ-005 SHALL have parameter IH, default 32, image height in pixels (IH >= KY).
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port i_in_valid, input, 1, pixel qualifier.
REQ-009 SHALL have port i_in_pixel, input, I_F_BW, raster-order pixel, row-major, top-left first.
REQ-010 SHALL have port o_ot_valid, output, 1, window qualifier, directly feeding the kernel i_in_valid.
REQ-011 SHALL have port o_ot_fmap, output, KX*KY*I_F_BW, window, directly feeding the kernel i_in_fmap.

Function
REQ-012 SHALL place window element (ky,kx) at bits [(ky*KX+kx)*I_F_BW +: I_F_BW]; ky=0 is the oldest (top) row, kx=0 the leftmost column.
REQ-013 SHALL generate stride-1, no-padding windows: (IH-KY+1)*(IW-KX+1) windows per frame.
REQ-014 SHALL track col counter (0..IW-1) and row counter (0..IH-1), advancing only when i_in_valid=1.
REQ-015 SHALL store the KY-1 previous rows in line buffers of IW entries each, indexed by col.
REQ-016 SHALL keep a KY x KX window shift register; each accepted pixel shifts in column {line buffers at col, i_in_pixel}.
REQ-017 SHALL implement FSM S_FILL (row < KY-1, no output) and S_RUN (row >= KY-1).
REQ-018 SHALL transition S_FILL->S_RUN on the accepted pixel at col=IW-1, row=KY-2.
REQ-019 SHALL transition S_RUN->S_FILL on the accepted pixel at col=IW-1, row=IH-1, and clear col and row to 0 (frame wrap).
REQ-020 SHALL assert o_ot_valid for exactly one cycle, the cycle after accepting a pixel with row >= KY-1 and col >= KX-1 (latency 1).
REQ-021 SHALL hold o_ot_fmap unchanged while o_ot_valid=0.
REQ-022 SHALL freeze all state during i_in_valid=0 gaps; gaps of any length are legal, including mid-row and at frame boundaries.
REQ-023 SHALL never emit a window spanning a row wrap (col < KX-1) or a frame wrap.
REQ-024 SHALL support back-to-back frames with no idle cycle between them.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, clear col, row, state (S_FILL), o_ot_valid=0, o_ot_fmap=0, and the window register.
REQ-026 SHALL, after reset mid-frame, treat the next accepted pixel as (0,0) of a new frame; line buffer contents need no reset.
REQ-027 SHALL give reset priority over a simultaneous i_in_valid=1; that pixel is dropped.

Configuration
REQ-028 SHALL, when CNN_WIN_STATUS_EN is defined, add output o_frame_done (1 bit, pulse coincident with the last window of a frame) and o_win_cnt ($clog2 of the window count, windows emitted in the current frame, cleared on reset and at frame wrap).
REQ-029 SHALL, when CNN_WIN_STATUS_EN is undefined, omit both ports and their logic; all other behaviour is identical.

Structure
REQ-030 SHALL take KX, KY, I_F_BW defaults and FSM state encodings from the shared CNN package used by cnn_kernel.
REQ-031 SHALL implement each line buffer as sub-module cnn_line_buf (IW x I_F_BW, write at col, synchronous-read-compatible timing).

Verification
REQ-032 SHALL test IW=5, IH=4, pixels p=r*5+c back-to-back: first o_ot_valid one cycle after pixel 12, window = {0,1,2,5,6,7,10,11,12}, elem0 at bits [7:0].
REQ-033 SHALL test same frame: exactly 6 windows; last = {7,8,9,12,13,14,17,18,19}; no window after pixels 15 and 16 (row wrap).
REQ-034 SHALL test random i_in_valid gaps (~50% duty): window sequence identical to the gap-free run; o_ot_fmap stable between valids.
REQ-035 SHALL test two consecutive frames with second frame pixels +100: second frame first window = {100,101,102,105,106,107,110,111,112}; no mixed-frame window.
REQ-036 SHALL test reset asserted after pixel 13: o_ot_valid=0 next cycle, then a fresh frame yields first window after its pixel 12.
REQ-037 SHALL test with CNN_WIN_STATUS_EN defined: o_frame_done pulses once with the 6th window, o_win_cnt reads 6 then 0 after the wrap.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN defaults, window FSM encoding and counter width helper
package cnn_pkg;
  localparam int KX_DEF = 3;
  localparam int KY_DEF = 3;
  localparam int I_F_BW_DEF = 8;
  typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} win_state_e;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cnn_line_buf.sv
// cnn_line_buf: one image row, read and written at the same column (read returns the previous row)
module cnn_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int W = I_F_BW_DEF,
  localparam int AW = cw(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o
);
  logic [W-1:0] mem_q [DEPTH];
  assign dout_o = mem_q[addr_i];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= din_i;
  end
endmodule

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: raster pixel stream to stride-1 KYxKX windows, latency 1
// CNN_WIN_STATUS_EN adds o_frame_done and o_win_cnt frame status outputs
module cnn_window_gen
  import cnn_pkg::*;
#(
  parameter int KX = KX_DEF,
  parameter int KY = KY_DEF,
  parameter int I_F_BW = I_F_BW_DEF,
  parameter int IW = 32,
  parameter int IH = 32
`ifdef CNN_WIN_STATUS_EN
  ,
  localparam int WCW = $clog2((IH-KY+1)*(IW-KX+1)+1)
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_in_valid,
  input  logic [I_F_BW-1:0]        i_in_pixel,
  output logic                     o_ot_valid,
  output logic [KX*KY*I_F_BW-1:0]  o_ot_fmap
`ifdef CNN_WIN_STATUS_EN
  ,
  output logic                     o_frame_done,
  output logic [WCW-1:0]           o_win_cnt
`endif
);
  localparam int CW = cw(IW);
  localparam int RW = cw(IH);
  win_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [I_F_BW-1:0] win_q [KY][KX];
  logic [I_F_BW-1:0] win_d [KY][KX];
  logic [I_F_BW-1:0] col_in [KY];
  logic [I_F_BW-1:0] lb_rd [KY-1];
  logic [KX*KY*I_F_BW-1:0] fmap_d;
  logic eol, eof, emit;
  // Buffers cascade: buffer g holds row r-1-g and is refilled with row r-g at the same column.
  for (genvar g = 0; g < KY-1; g++) begin : g_lb
    cnn_line_buf #(.DEPTH(IW), .W(I_F_BW)) u_lb (
      .clk    (clk),
      .we_i   (i_in_valid & ~reset),
      .addr_i (col_q),
      .din_i  (col_in[KY-1-g]),
      .dout_o (lb_rd[g])
    );
  end
  always_comb begin
    eol = col_q == CW'(IW-1);
    eof = eol && row_q == RW'(IH-1);
    emit = i_in_valid && state_q == S_RUN && col_q >= CW'(KX-1);
    col_d = !i_in_valid ? col_q : eol ? '0 : col_q + 1'b1;
    row_d = !(i_in_valid && eol) ? row_q : eof ? '0 : row_q + 1'b1;
    state_d = state_q;
    if (i_in_valid && eol)
      state_d = state_q == S_FILL ? (row_q == RW'(KY-2) ? S_RUN : S_FILL) : (eof ? S_FILL : S_RUN);
    col_in[KY-1] = i_in_pixel;
    for (int k = 0; k < KY-1; k++) col_in[k] = lb_rd[KY-2-k];
    win_d = win_q;
    if (i_in_valid) begin
      for (int y = 0; y < KY; y++) begin
        for (int x = 0; x < KX-1; x++) win_d[y][x] = win_q[y][x+1];
        win_d[y][KX-1] = col_in[y];
      end
    end
    for (int y = 0; y < KY; y++)
      for (int x = 0; x < KX; x++) fmap_d[(y*KX+x)*I_F_BW +: I_F_BW] = win_d[y][x];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
      o_ot_valid <= 1'b0;
      o_ot_fmap <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      o_ot_valid <= emit;
      if (emit) o_ot_fmap <= fmap_d;
    end
  end
`ifdef CNN_WIN_STATUS_EN
  // Count drops to zero the cycle after the frame's last window is shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_frame_done <= 1'b0;
      o_win_cnt <= '0;
    end else begin
      o_frame_done <= emit && eof;
      o_win_cnt <= o_frame_done ? '0 : emit ? o_win_cnt + 1'b1 : o_win_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: scoreboard bench for cnn_window_gen on a 5x4 image with a 3x3 kernel
module tb_cnn_window_gen;
  localparam int KX = 3, KY = 3, BW = 8, IW = 5, IH = 4;
  localparam int WW = KX*KY*BW;
  localparam int NPIX = IW*IH;
  typedef struct {
    logic [WW-1:0] win;
    int due;
    bit last;
    int cnt;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, i_in_valid = 1'b0;
  logic [BW-1:0] i_in_pixel = '0;
  logic o_ot_valid;
  logic [WW-1:0] o_ot_fmap;
`ifdef CNN_WIN_STATUS_EN
  localparam int WCW = $clog2((IH-KY+1)*(IW-KX+1)+1);
  logic o_frame_done;
  logic [WCW-1:0] o_win_cnt;
  logic prev_done = 1'b0;
`endif
  exp_t sb[$];
  logic [WW-1:0] got[$];
  logic [WW-1:0] ref_win[$];
  logic [BW-1:0] img [NPIX];
  int pos = 0, cyc = 0, n_chk = 0, n_pass = 0;
  logic pend_rst = 1'b0;
  logic [WW-1:0] last_fmap = '0;
  cnn_window_gen #(.KX(KX), .KY(KY), .I_F_BW(BW), .IW(IW), .IH(IH)) dut (
    .clk(clk),
    .reset(reset),
    .i_in_valid(i_in_valid),
    .i_in_pixel(i_in_pixel),
    .o_ot_valid(o_ot_valid),
    .o_ot_fmap(o_ot_fmap)
`ifdef CNN_WIN_STATUS_EN
    ,
    .o_frame_done(o_frame_done),
    .o_win_cnt(o_win_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask
  // Reference: keep the frame as an image and cut each window straight out of it.
  task automatic drive(input logic v, input logic [BW-1:0] p, input logic r);
    exp_t e;
    int rr, cc;
    i_in_valid = v;
    i_in_pixel = p;
    reset = r;
    if (r) pos = 0;
    else if (v) begin
      img[pos] = p;
      rr = pos / IW;
      cc = pos % IW;
      if (rr >= KY-1 && cc >= KX-1) begin
        for (int y = 0; y < KY; y++)
          for (int x = 0; x < KX; x++)
            e.win[(y*KX+x)*BW +: BW] = img[(rr-KY+1+y)*IW + cc-KX+1+x];
        e.due = cyc + 1;
        e.last = pos == NPIX-1;
        e.cnt = (rr-KY+1)*(IW-KX+1) + cc-KX+2;
        sb.push_back(e);
      end
      pos = (pos + 1) % NPIX;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [BW-1:0] p, input bit gaps);
    while (gaps && $urandom_range(1) == 0) drive(1'b0, BW'($urandom), 1'b0);
    drive(1'b1, p, 1'b0);
  endtask
  task automatic frame(input int base, input bit gaps);
    for (int i = 0; i < NPIX; i++) send(BW'(base + i), gaps);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, BW'($urandom), 1'b0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (pend_rst) begin
      check("reset_valid", WW'(o_ot_valid), '0);
      check("reset_fmap", o_ot_fmap, '0);
`ifdef CNN_WIN_STATUS_EN
      check("reset_win_cnt", WW'(o_win_cnt), '0);
`endif
      last_fmap = '0;
    end else if (o_ot_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_window at cycle %0d: got %h, expected no window", cyc, o_ot_fmap);
      end else begin
        e = sb.pop_front();
        check("window", o_ot_fmap, e.win);
        check("latency_cycle", WW'(cyc), WW'(e.due));
`ifdef CNN_WIN_STATUS_EN
        check("frame_done", WW'(o_frame_done), WW'(e.last));
        check("win_cnt", WW'(o_win_cnt), WW'(e.cnt));
`endif
      end
      got.push_back(o_ot_fmap);
      last_fmap = o_ot_fmap;
    end else begin
      check("fmap_hold", o_ot_fmap, last_fmap);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_chk++;
        $display("FAIL missing_window at cycle %0d: got no window, expected %h", cyc, sb[0].win);
        void'(sb.pop_front());
      end
`ifdef CNN_WIN_STATUS_EN
      check("frame_done_idle", WW'(o_frame_done), '0);
`endif
    end
`ifdef CNN_WIN_STATUS_EN
    if (prev_done) check("win_cnt_wrap", WW'(o_win_cnt), '0);
    prev_done = o_ot_valid && o_frame_done;
`endif
    pend_rst = reset;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [WW-1:0] w_first, w_last, w_f2;
    w_first = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
    w_last = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};
    w_f2 = {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100};
    repeat (3) @(posedge clk);
    #1;
    idle(2);
    got.delete();
    frame(0, 1'b0);
    frame(100, 1'b0);
    idle(3);
    check("two_frame_window_count", WW'(got.size()), WW'(12));
    if (got.size() == 12) begin
      check("first_window", got[0], w_first);
      check("last_window", got[5], w_last);
      check("frame2_first_window", got[6], w_f2);
      for (int i = 0; i < 6; i++) ref_win.push_back(got[i]);
    end
    got.delete();
    frame(0, 1'b1);
    idle(3);
    check("gap_window_count", WW'(got.size()), WW'(6));
    for (int i = 0; i < got.size() && i < ref_win.size(); i++) check("gap_window_seq", got[i], ref_win[i]);
    got.delete();
    for (int i = 0; i < 14; i++) send(BW'(i), 1'b0);
    drive(1'b1, 8'd77, 1'b1);
    frame(0, 1'b0);
    idle(3);
    check("reset_window_count", WW'(got.size()), WW'(8));
    if (got.size() == 8) check("post_reset_first_window", got[2], w_first);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(79) == 0) drive(1'b1, BW'($urandom), 1'b1);
      else send(BW'($urandom), 1'b1);
    end
    idle(4);
    check("scoreboard_drained", WW'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
